// File: rtl/ball_motion_integrator.sv
// ball_motion_integrator
// Two-axis ball physics engine. A programmable physics tick launches a
// VEL -> POS -> BOUND sequence that integrates signed tilt acceleration into
// Q(FRAC) velocity and position, clamps the position at the walls and
// reflects the velocity with a restitution loss. Pixel coordinates and
// velocities presented to the renderer change only together with o_update.
// Axis arrays are indexed 0 = X, 1 = Y.
// Build option: define FRICTION_EN to add per-tick velocity decay
// (parameter FRIC_SHIFT).

module ball_motion_integrator #(
  parameter int ACC_W      = 8,
  parameter int ACC_SHIFT  = 0,
  parameter int VEL_W      = 24,
  parameter int POS_W      = 10,
  parameter int FRAC       = 8,
  parameter int TICK_DIV   = 1000,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 180,
  parameter int SPRITE     = 32,
  parameter int REST_SHIFT = 2,
  parameter int INIT_X     = 100,
  parameter int INIT_Y     = 50
`ifdef FRICTION_EN
  , parameter int FRIC_SHIFT = 6
`endif
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    i_moving,
  input  logic                    i_load,
  input  logic        [POS_W-1:0] i_init_x,
  input  logic        [POS_W-1:0] i_init_y,
  input  logic signed [ACC_W-1:0] i_accel_x,
  input  logic signed [ACC_W-1:0] i_accel_y,
  output logic        [POS_W-1:0] o_pos_x,
  output logic        [POS_W-1:0] o_pos_y,
  output logic signed [VEL_W-1:0] o_vel_x,
  output logic signed [VEL_W-1:0] o_vel_y,
  output logic                    o_update,
  output logic                    o_hit_x,
  output logic                    o_hit_y
);

  // Internal position width: integer pixels, fraction, sign and one guard
  // bit so that overshoot past either wall is still representable.
  localparam int PW    = POS_W + FRAC + 2;
  // Velocity adder width: wide enough for the shifted acceleration plus a
  // carry bit so saturation can be detected before truncation.
  localparam int AW    = ACC_W + ACC_SHIFT;
  localparam int SW    = ((VEL_W > AW) ? VEL_W : AW) + 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_X = SCREEN_W - SPRITE;
  localparam int MAX_Y = SCREEN_H - SPRITE;

  localparam logic signed [PW-1:0] MAX_PX  = PW'(MAX_X * (2 ** FRAC));
  localparam logic signed [PW-1:0] MAX_PY  = PW'(MAX_Y * (2 ** FRAC));
  localparam logic signed [PW-1:0] INIT_PX = PW'(INIT_X * (2 ** FRAC));
  localparam logic signed [PW-1:0] INIT_PY = PW'(INIT_Y * (2 ** FRAC));
  localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICK_DIV - 1);

  // Saturation bounds of the velocity register, expressed at adder width.
  localparam logic signed [SW-1:0] V_MAX = {{(SW - VEL_W + 1){1'b0}}, {(VEL_W - 1){1'b1}}};
  localparam logic signed [SW-1:0] V_MIN = {{(SW - VEL_W + 1){1'b1}}, {(VEL_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEL,
    S_POS,
    S_BOUND
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  logic signed [ACC_W-1:0] accel [2];
  logic        [POS_W-1:0] init  [2];
  logic signed [PW-1:0]    max_p [2];

  logic signed [PW-1:0]    p_q   [2];
  logic signed [VEL_W-1:0] v_q   [2];
  logic signed [PW-1:0]    v_ext [2];

  logic signed [PW-1:0]    p_bnd [2];
  logic signed [VEL_W-1:0] v_bnd [2];
  logic        [1:0]       hit_bnd;

  logic        [POS_W-1:0] pos_q [2];
  logic signed [VEL_W-1:0] vel_q [2];
  logic        [1:0]       hit_q;
  logic                    upd_q;

  assign accel[0] = i_accel_x;
  assign accel[1] = i_accel_y;
  assign init[0]  = i_init_x;
  assign init[1]  = i_init_y;
  assign max_p[0] = MAX_PX;
  assign max_p[1] = MAX_PY;

  // Velocity step: optional decay, add shifted acceleration, saturate.
  function automatic logic signed [VEL_W-1:0] vel_step(
    input logic signed [VEL_W-1:0] v,
    input logic signed [ACC_W-1:0] a
  );
    logic signed [VEL_W-1:0] base;
    logic signed [SW-1:0]    sum;
`ifdef FRICTION_EN
    base = v - (v >>> FRIC_SHIFT);
`else
    base = v;
`endif
    sum = SW'(base) + (SW'(a) <<< ACC_SHIFT);
    if (sum > V_MAX) begin
      sum = V_MAX;
    end else if (sum < V_MIN) begin
      sum = V_MIN;
    end
    return VEL_W'(sum);
  endfunction

  // Wall bounce: reverse direction and drop 1/2^REST_SHIFT of the speed;
  // a zero shift means the ball sticks to the wall.
  function automatic logic signed [VEL_W-1:0] reflect(
    input logic signed [VEL_W-1:0] v
  );
    if (REST_SHIFT == 0) begin
      return '0;
    end
    return -(v - (v >>> REST_SHIFT));
  endfunction

  // Physics tick: free-running divider that only advances while moving.
  assign tick = i_moving && (tick_cnt == TICK_LAST);

  // Tick divider register; a load restarts the physics period.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (rst || i_load) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else if (i_moving) begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // FSM state register; a load aborts any update in flight.
  always_ff @(posedge CLK) begin
    if (rst || i_load) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: one cycle per phase, started by the tick.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (tick) state_next = S_VEL;
      S_VEL:   state_next = S_POS;
      S_POS:   state_next = S_BOUND;
      S_BOUND: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Velocity contribution in position width (truncate or sign-extend).
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      v_ext[i] = PW'(v_q[i]);
    end
  end

  // Wall clamp and bounce, evaluated per axis independently. Landing
  // exactly on 0 or the far wall is not a hit.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      p_bnd[i]   = p_q[i];
      v_bnd[i]   = v_q[i];
      hit_bnd[i] = 1'b0;
      if (p_q[i] < 0) begin
        p_bnd[i]   = '0;
        hit_bnd[i] = 1'b1;
      end else if (p_q[i] > max_p[i]) begin
        p_bnd[i]   = max_p[i];
        hit_bnd[i] = 1'b1;
      end
      if (hit_bnd[i]) begin
        v_bnd[i] = reflect(v_q[i]);
      end
    end
  end

  // Datapath and committed outputs, advanced by the FSM phase.
  always_ff @(posedge CLK) begin
    if (rst) begin
      p_q[0]   <= INIT_PX;
      p_q[1]   <= INIT_PY;
      pos_q[0] <= POS_W'(INIT_X);
      pos_q[1] <= POS_W'(INIT_Y);
      for (int i = 0; i < 2; i++) begin
        v_q[i]   <= '0;
        vel_q[i] <= '0;
      end
      hit_q <= '0;
      upd_q <= 1'b0;
    end else if (i_load) begin
      for (int i = 0; i < 2; i++) begin
        p_q[i]   <= {2'b00, init[i], {FRAC{1'b0}}};
        pos_q[i] <= init[i];
        v_q[i]   <= '0;
        vel_q[i] <= '0;
      end
      hit_q <= '0;
      upd_q <= 1'b0;
    end else begin
      hit_q <= '0;
      upd_q <= 1'b0;
      case (state)
        S_VEL: begin
          for (int i = 0; i < 2; i++) begin
            v_q[i] <= vel_step(v_q[i], accel[i]);
          end
        end
        S_POS: begin
          for (int i = 0; i < 2; i++) begin
            p_q[i] <= p_q[i] + v_ext[i];
          end
        end
        S_BOUND: begin
          for (int i = 0; i < 2; i++) begin
            p_q[i]   <= p_bnd[i];
            v_q[i]   <= v_bnd[i];
            pos_q[i] <= p_bnd[i][FRAC +: POS_W];
            vel_q[i] <= v_bnd[i];
          end
          hit_q <= hit_bnd;
          upd_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_pos_x  = pos_q[0];
  assign o_pos_y  = pos_q[1];
  assign o_vel_x  = vel_q[0];
  assign o_vel_y  = vel_q[1];
  assign o_hit_x  = hit_q[0];
  assign o_hit_y  = hit_q[1];
  assign o_update = upd_q;

endmodule
